acc_exec_unit: RTL and testbench
================================

# acc_exec_unit

Sequential accumulator execution unit that issues operations to the existing 8-bit arithmetic and logic datapath and consumes its result and NZVC flags. It accepts one command at a time over a valid/ready handshake and holds an 8-bit accumulator and a 4-bit flag register. It adds a multi-cycle shift-add multiply, built on the ripple adder, and returns each result over a valid/ready response channel. It sits between an instruction sequencer (upstream) and a register/writeback stage (downstream).

## Interface
- No parameters; all widths fixed at 8 bits.
- Clock  in  1  rising-edge clock
- Reset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command
- cmd_op  in  4  opcode
- cmd_operand  in  8  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream takes the response
- rsp_result  out  8  result, equal to the new accumulator value
- rsp_flags  out  4  {N,Z,V,C} after the operation
- rsp_err  out  1  illegal opcode
- acc  out  8  current accumulator

## Operation
- Opcodes:
  - 0 ADD: acc+B
  - 1 INC: acc+1
  - 2 SUB: acc-B
  - 3 DEC: acc-1
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT: ~acc
  - 8 LOAD: acc=B
  - 9 MUL: low byte of acc*B
  - 10-15: illegal
- All arithmetic is modulo 256.
- N and Z are set from the 8-bit result for every legal op.
- ADD: C=carry-out. V=(A7==B7)&&(R7!=A7).
- SUB: C=1 when no borrow (acc>=B, unsigned). V=(A7!=B7)&&(R7!=A7).
- INC, DEC, logic ops and LOAD: V=0, C=0.
- MUL: V=0. C=1 when the high byte of the 16-bit product is nonzero.
- Illegal op: acc and flag register unchanged. Response carries rsp_result=acc, rsp_flags=current flags, rsp_err=1.
- State machine:
  - IDLE: cmd_ready=1. Accepting a command latches op and operand. Goes to MUL if op==9, otherwise EXEC.
  - EXEC: compute, write acc, flags and response registers, go to RESP.
  - MUL: 4-bit iteration counter 0..7. Each cycle, if multiplier bit[i] is set, add the multiplicand shifted left by i into a 16-bit partial product. At count 7, write results and go to RESP.
  - RESP: rsp_valid=1. When rsp_ready is high, go to IDLE.
- MUL uses the acc value latched at accept as the multiplicand. The visible acc does not change until the final write.
- cmd_ready is 0 in EXEC, MUL and RESP. Commands presented then are not accepted and must be held by the source.

## Timing
- Reset values: acc=0x00, flags=0000, rsp_result=0x00, rsp_flags=0000, rsp_err=0, rsp_valid=0, state IDLE, cmd_ready=1.
- Accept happens on the edge where cmd_valid&&cmd_ready; call it E0.
- Non-MUL ops: results are written at E1, and rsp_valid is high from E1.
- MUL: iterations run at E1..E8, results are written at E8, and rsp_valid is high from E8.
- The response is consumed on the edge where rsp_valid&&rsp_ready; cmd_ready is high from that edge.
- Minimum command spacing is 3 cycles for non-MUL ops and 10 cycles for MUL.
- Backpressure: while rsp_ready=0, rsp_result, rsp_flags and rsp_err stay constant and rsp_valid stays high.
- The response is registered; there is no combinational path from cmd_* to rsp_*.
- Reset asserted in any state, including mid-MUL, immediately forces all reset values and drops any in-flight command. No response is produced after release.

## Test plan
- Reset, then LOAD 0x7F -> rsp_valid at E1, rsp_result=0x7F, flags=0000, rsp_err=0.
- acc=0x7F, ADD 0x01 -> 0x80, NZVC=1010. Then ADD 0x80 -> 0x00, NZVC=0111.
- acc=0x80, SUB 0x80 -> 0x00, NZVC=0101. Then DEC -> 0xFF, NZVC=1000.
- acc=0x10, MUL 0x11 -> rsp_valid first at E8, rsp_result=0x10, NZVC=0001. acc reads 0x10 unchanged during E1..E7.
- Hold rsp_ready=0 for 5 cycles, then opcode 0xF -> response held stable with cmd_ready=0 throughout. Illegal op returns rsp_err=1 with acc and flags unchanged.
- acc=0x05, MUL 0x03, Reset pulsed low at iteration 4 -> acc=0x00, flags=0000, rsp_valid=0, cmd_ready=1. No response after release.

Source files
------------

// File: rtl/acc_exec_unit.sv
// Accumulator execution unit: 8-bit ALU ops plus an iterative shift-add
// multiply, with valid/ready command and response channels.

module acc_ripple_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];
endmodule

module acc_exec_unit (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_operand,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] acc
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_INC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [7:0]  opnd_q;
    logic [7:0]  mcand_q;
    logic [15:0] prod_q;
    logic [3:0]  cnt_q;
    logic [7:0]  acc_q;
    logic [3:0]  flags_q;

    logic        accept;
    logic        mul_last;

    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    logic [7:0]  alu_res;
    logic        alu_v;
    logic        alu_c;
    logic        alu_err;
    logic [3:0]  alu_flags;

    logic [15:0] mul_addend;
    logic [15:0] prod_nxt;
    logic        mul_cout;
    logic [3:0]  mul_flags;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign acc       = acc_q;
    assign accept    = cmd_valid && cmd_ready;
    assign mul_last  = (cnt_q == 4'd7);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction runs as acc + ~B + 1 so carry-out reads as "no borrow".
    always_comb begin
        add_b   = opnd_q;
        add_cin = 1'b0;
        unique case (op_q)
            OP_INC:  add_b = 8'h01;
            OP_SUB: begin
                add_b   = ~opnd_q;
                add_cin = 1'b1;
            end
            OP_DEC:  add_b = 8'hFF;
            default: add_b = opnd_q;
        endcase
    end

    acc_ripple_add #(.W(8)) u_alu_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        alu_res = acc_q;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_res = add_sum;
                alu_c   = add_cout;
                alu_v   = (acc_q[7] == opnd_q[7]) && (add_sum[7] != acc_q[7]);
            end
            OP_INC:  alu_res = add_sum;
            OP_SUB: begin
                alu_res = add_sum;
                alu_c   = add_cout;
                alu_v   = (acc_q[7] != opnd_q[7]) && (add_sum[7] != acc_q[7]);
            end
            OP_DEC:  alu_res = add_sum;
            OP_AND:  alu_res = acc_q & opnd_q;
            OP_OR:   alu_res = acc_q | opnd_q;
            OP_XOR:  alu_res = acc_q ^ opnd_q;
            OP_NOT:  alu_res = ~acc_q;
            OP_LOAD: alu_res = opnd_q;
            default: alu_err = 1'b1;
        endcase
    end

    assign alu_flags = {alu_res[7], (alu_res == 8'h00), alu_v, alu_c};

    // One partial product per cycle, LSB of the multiplier first.
    assign mul_addend = opnd_q[cnt_q[2:0]]
                      ? ({8'h00, mcand_q} << cnt_q[2:0])
                      : 16'h0000;

    acc_ripple_add #(.W(16)) u_mul_add (
        .a    (prod_q),
        .b    (mul_addend),
        .cin  (1'b0),
        .sum  (prod_nxt),
        .cout (mul_cout)
    );

    assign mul_flags = {prod_nxt[7], (prod_nxt[7:0] == 8'h00),
                        1'b0, (prod_nxt[15:8] != 8'h00)};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            op_q       <= 4'h0;
            opnd_q     <= 8'h00;
            mcand_q    <= 8'h00;
            prod_q     <= 16'h0000;
            cnt_q      <= 4'h0;
            acc_q      <= 8'h00;
            flags_q    <= 4'h0;
            rsp_result <= 8'h00;
            rsp_flags  <= 4'h0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= cmd_op;
                        opnd_q  <= cmd_operand;
                        mcand_q <= acc_q;
                        prod_q  <= 16'h0000;
                        cnt_q   <= 4'h0;
                    end
                end
                S_EXEC: begin
                    if (!alu_err) begin
                        acc_q   <= alu_res;
                        flags_q <= alu_flags;
                    end
                    rsp_result <= alu_res;
                    rsp_flags  <= alu_err ? flags_q : alu_flags;
                    rsp_err    <= alu_err;
                end
                S_MUL: begin
                    prod_q <= prod_nxt;
                    cnt_q  <= cnt_q + 4'd1;
                    if (mul_last) begin
                        acc_q      <= prod_nxt[7:0];
                        flags_q    <= mul_flags;
                        rsp_result <= prod_nxt[7:0];
                        rsp_flags  <= mul_flags;
                        rsp_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    logic unused;
    assign unused = mul_cout;
endmodule

// File: tb/tb_acc_exec_unit.sv
// Self-checking bench for acc_exec_unit: reference model feeds a response
// scoreboard that is checked when the unit hands back each result.

module tb_acc_exec_unit;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'h0;
    logic [7:0] cmd_operand = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    logic [7:0] acc;

    typedef struct packed {
        logic [7:0] result;
        logic [3:0] flags;
        logic       err;
    } rsp_t;

    rsp_t       sb[$];
    logic [7:0] m_acc = 8'h00;
    logic [3:0] m_flags = 4'h0;
    int         vectors = 0;
    int         errors = 0;

    always #5 Clock = ~Clock;

    acc_exec_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .acc         (acc)
    );

    function automatic rsp_t model(input logic [3:0] op, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  a;
        logic [7:0]  r;
        logic        v;
        logic        c;
        a = m_acc;
        r = a;
        v = 1'b0;
        c = 1'b0;
        if (op > 4'd9) return {a, m_flags, 1'b1};
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: r = a + 8'd1;
            4'd2: begin
                r = a - b;
                c = (a >= b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd3: r = a - 8'd1;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~a;
            4'd8: r = b;
            default: begin
                p = 16'(a) * 16'(b);
                r = p[7:0];
                c = (p[15:8] != 8'h00);
            end
        endcase
        m_acc   = r;
        m_flags = {r[7], (r == 8'h00), v, c};
        return {r, m_flags, 1'b0};
    endfunction

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = b;
        sb.push_back(model(op, b));
        @(negedge Clock);
        cmd_valid = 1'b0;
    endtask

    // lat counts falling edges waited before rsp_valid was seen.
    task automatic collect(output rsp_t got, output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        got = {rsp_result, rsp_flags, rsp_err};
        rsp_ready = 1'b1;
        @(negedge Clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        @(negedge Clock);
        vectors++;
        if ({acc, rsp_result, rsp_flags, rsp_err, rsp_valid, cmd_ready} !==
            {8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: acc=%h res=%h flg=%b err=%b v=%b rdy=%b required 00 00 0000 0 0 1",
                     acc, rsp_result, rsp_flags, rsp_err, rsp_valid, cmd_ready);
        end
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_arith();
        logic [3:0] ops[6]  = '{4'd8, 4'd0, 4'd0, 4'd8, 4'd2, 4'd3};
        logic [7:0] opnd[6] = '{8'h7F, 8'h01, 8'h80, 8'h80, 8'h80, 8'h00};
        rsp_t got;
        rsp_t exp;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], opnd[i]);
            collect(got, lat);
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL arith[%0d]: got %h/%b/%b required %h/%b/%b",
                         i, got.result, got.flags, got.err,
                         exp.result, exp.flags, exp.err);
            end
            vectors++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL arith_lat[%0d]: latency %0d required 1", i, lat);
            end
            vectors++;
            if (acc !== m_acc) begin
                errors++;
                $display("FAIL arith_acc[%0d]: acc=%h required %h", i, acc, m_acc);
            end
        end
    endtask

    task automatic test_mul();
        rsp_t got;
        rsp_t exp;
        int   lat;
        issue(4'd8, 8'h10);
        collect(got, lat);
        exp = sb.pop_front();
        issue(4'd9, 8'h11);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({acc, rsp_valid, cmd_ready} !== {8'h10, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL mul_busy[%0d]: acc=%h v=%b rdy=%b required 10 0 0",
                         i, acc, rsp_valid, cmd_ready);
            end
            @(negedge Clock);
        end
        collect(got, lat);
        exp = sb.pop_front();
        vectors++;
        if (got !== {8'h10, 4'b0001, 1'b0} || got !== exp) begin
            errors++;
            $display("FAIL mul_0x10x11: got %h/%b/%b required %h/%b/%b",
                     got.result, got.flags, got.err,
                     exp.result, exp.flags, exp.err);
        end
        vectors++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL mul_lat: rsp_valid missing after E8 (waited %0d more)", lat);
        end
        issue(4'd8, 8'h0D);
        collect(got, lat);
        exp = sb.pop_front();
        issue(4'd9, 8'h0B);
        collect(got, lat);
        exp = sb.pop_front();
        vectors++;
        if (got !== exp || lat !== 8) begin
            errors++;
            $display("FAIL mul_0x0Dx0B: got %h/%b lat %0d required %h/%b lat 8",
                     got.result, got.flags, lat, exp.result, exp.flags);
        end
    endtask

    task automatic test_backpressure_illegal();
        rsp_t got;
        rsp_t exp;
        int   lat;
        issue(4'd8, 8'h80);
        @(negedge Clock);
        exp = sb.pop_front();
        cmd_valid   = 1'b1;
        cmd_op      = 4'hF;
        cmd_operand = 8'h55;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({rsp_valid, cmd_ready, rsp_result, rsp_flags, rsp_err} !==
                {1'b1, 1'b0, exp.result, exp.flags, exp.err}) begin
                errors++;
                $display("FAIL hold[%0d]: v=%b rdy=%b %h/%b/%b required 1 0 %h/%b/%b",
                         i, rsp_valid, cmd_ready, rsp_result, rsp_flags, rsp_err,
                         exp.result, exp.flags, exp.err);
            end
            @(negedge Clock);
        end
        rsp_ready = 1'b1;
        @(negedge Clock);
        rsp_ready = 1'b0;
        sb.push_back(model(4'hF, 8'h55));
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge Clock);
        cmd_valid = 1'b0;
        collect(got, lat);
        exp = sb.pop_front();
        vectors++;
        if (got !== {8'h80, 4'b1000, 1'b1} || got !== exp || lat !== 1) begin
            errors++;
            $display("FAIL illegal: got %h/%b/%b lat %0d required %h/%b/%b lat 1",
                     got.result, got.flags, got.err, lat,
                     exp.result, exp.flags, exp.err);
        end
        vectors++;
        if (acc !== 8'h80) begin
            errors++;
            $display("FAIL illegal_acc: acc=%h required 80", acc);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t       got;
        rsp_t       exp;
        int         lat;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, 8'($urandom));
            collect(got, lat);
            exp = sb.pop_front();
            vectors++;
            if (got !== exp || lat !== ((op == 4'd9) ? 8 : 1)) begin
                errors++;
                $display("FAIL b2b[%0d] op %0d: got %h/%b/%b lat %0d required %h/%b/%b",
                         i, op, got.result, got.flags, got.err, lat,
                         exp.result, exp.flags, exp.err);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        rsp_t got;
        int   lat;
        logic seen = 1'b0;
        issue(4'd8, 8'h05);
        collect(got, lat);
        void'(sb.pop_front());
        issue(4'd9, 8'h03);
        repeat (4) @(negedge Clock);
        Reset = 1'b0;
        #1;
        m_acc   = 8'h00;
        m_flags = 4'h0;
        sb.delete();
        vectors++;
        if ({acc, rsp_result, rsp_flags, rsp_err, rsp_valid, cmd_ready} !==
            {8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_mul_reset: acc=%h res=%h flg=%b v=%b rdy=%b required 00 00 0000 0 1",
                     acc, rsp_result, rsp_flags, rsp_valid, cmd_ready);
        end
        @(negedge Clock);
        Reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (12) begin
            @(negedge Clock);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        vectors++;
        if (seen || acc !== 8'h00 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: stray_rsp=%b acc=%h rdy=%b required 0 00 1",
                     seen, acc, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mul();
        test_backpressure_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
